// File: rtl/seg_buffer_stream.sv
// Segment buffer rectangle streamer: bounding box of (A,B) grown by dist, emitted as 4 vertices.
// Latency: segment accepted at edge k gives first vertex valid after edge k+1, last beat at k+5 with no stalls.
// Backpressure: one segment in flight (in_ready only in IDLE); vertex outputs hold while out_ready=0.
// Optional SEG_BUFFER_SATURATE_EN: clamp out-of-range corners and flag out_clip (default: wrap, out_clip=0).
module seg_buffer_stream #(
    parameter int COORD_W = 8,
    parameter int DIST_W  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [COORD_W-1:0] in_ax,
    input  logic [COORD_W-1:0] in_ay,
    input  logic [COORD_W-1:0] in_bx,
    input  logic [COORD_W-1:0] in_by,
    input  logic [DIST_W-1:0]  in_dist,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [COORD_W-1:0] out_x,
    output logic [COORD_W-1:0] out_y,
    output logic [1:0]         out_idx,
    output logic               out_last,
    output logic               out_clip,
    output logic               busy
);

    typedef enum logic [1:0] {IDLE, CALC, EMIT} state_t;

    state_t             state;
    logic [COORD_W-1:0] ax_q, ay_q, bx_q, by_q;
    logic [DIST_W-1:0]  dist_q;
    logic [COORD_W-1:0] xlo_q, xhi_q, ylo_q, yhi_q;

    logic [COORD_W-1:0] dist_ext;
    logic [COORD_W-1:0] xmin, xmax, ymin, ymax;
    logic [COORD_W-1:0] xlo_n, xhi_n, ylo_n, yhi_n;
    logic               degen_n;
    logic [1:0]         nxt_idx;
    logic [COORD_W-1:0] nxt_x, nxt_y;

`ifdef SEG_BUFFER_SATURATE_EN
    logic [COORD_W:0]   xlo_w, xhi_w, ylo_w, yhi_w;
    logic               clip_n;
    logic               clip_q;
`endif

    assign in_ready = (state == IDLE) & rst_n;
    assign busy     = (state != IDLE);

    // Corner arithmetic on the captured segment; the extra top bit flags under/overflow.
    always_comb begin
        dist_ext = COORD_W'(dist_q);
        xmin = (ax_q < bx_q) ? ax_q : bx_q;
        xmax = (ax_q < bx_q) ? bx_q : ax_q;
        ymin = (ay_q < by_q) ? ay_q : by_q;
        ymax = (ay_q < by_q) ? by_q : ay_q;
`ifdef SEG_BUFFER_SATURATE_EN
        xlo_w  = {1'b0, xmin} - {1'b0, dist_ext};
        xhi_w  = {1'b0, xmax} + {1'b0, dist_ext};
        ylo_w  = {1'b0, ymin} - {1'b0, dist_ext};
        yhi_w  = {1'b0, ymax} + {1'b0, dist_ext};
        xlo_n  = xlo_w[COORD_W] ? '0 : xlo_w[COORD_W-1:0];
        xhi_n  = xhi_w[COORD_W] ? '1 : xhi_w[COORD_W-1:0];
        ylo_n  = ylo_w[COORD_W] ? '0 : ylo_w[COORD_W-1:0];
        yhi_n  = yhi_w[COORD_W] ? '1 : yhi_w[COORD_W-1:0];
        clip_n = xlo_w[COORD_W] | xhi_w[COORD_W] | ylo_w[COORD_W] | yhi_w[COORD_W];
`else
        // Only the low COORD_W bits survive when wrapping, so compute at that width.
        xlo_n = xmin - dist_ext;
        xhi_n = xmax + dist_ext;
        ylo_n = ymin - dist_ext;
        yhi_n = ymax + dist_ext;
`endif
        degen_n = (xlo_n == xhi_n) & (ylo_n == yhi_n);
    end

    // Next vertex in the order (lo,lo) (hi,lo) (hi,hi) (lo,hi).
    always_comb begin
        nxt_idx = out_idx + 2'd1;
        nxt_x   = (nxt_idx == 2'd1 || nxt_idx == 2'd2) ? xhi_q : xlo_q;
        nxt_y   = (nxt_idx[1]) ? yhi_q : ylo_q;
    end

    // Control FSM with registered vertex outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            ax_q      <= '0;
            ay_q      <= '0;
            bx_q      <= '0;
            by_q      <= '0;
            dist_q    <= '0;
            xlo_q     <= '0;
            xhi_q     <= '0;
            ylo_q     <= '0;
            yhi_q     <= '0;
            out_valid <= 1'b0;
            out_x     <= '0;
            out_y     <= '0;
            out_idx   <= 2'd0;
            out_last  <= 1'b0;
`ifdef SEG_BUFFER_SATURATE_EN
            clip_q    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        ax_q   <= in_ax;
                        ay_q   <= in_ay;
                        bx_q   <= in_bx;
                        by_q   <= in_by;
                        dist_q <= in_dist;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    xlo_q     <= xlo_n;
                    xhi_q     <= xhi_n;
                    ylo_q     <= ylo_n;
                    yhi_q     <= yhi_n;
                    out_valid <= 1'b1;
                    out_x     <= xlo_n;
                    out_y     <= ylo_n;
                    out_idx   <= 2'd0;
                    out_last  <= degen_n;
`ifdef SEG_BUFFER_SATURATE_EN
                    clip_q    <= clip_n;
`endif
                    state     <= EMIT;
                end
                EMIT: begin
                    if (out_ready) begin
                        if (out_last) begin
                            out_valid <= 1'b0;
                            out_x     <= '0;
                            out_y     <= '0;
                            out_idx   <= 2'd0;
                            out_last  <= 1'b0;
`ifdef SEG_BUFFER_SATURATE_EN
                            clip_q    <= 1'b0;
`endif
                            state     <= IDLE;
                        end else begin
                            out_idx  <= nxt_idx;
                            out_x    <= nxt_x;
                            out_y    <= nxt_y;
                            out_last <= (nxt_idx == 2'd3);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SEG_BUFFER_SATURATE_EN
    assign out_clip = clip_q;
`else
    assign out_clip = 1'b0;
`endif

endmodule

// File: tb/tb_seg_buffer_stream.sv
// Directed bench for seg_buffer_stream: hand-computed rectangles, latency, backpressure, reset.
// Inputs change and outputs are sampled on the falling edge of clk.
// Build with +define+SEG_BUFFER_SATURATE_EN to select the clamped expectations of the clipping case.
module tb_seg_buffer_stream;

    localparam int COORD_W = 8;
    localparam int DIST_W  = 4;

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [COORD_W-1:0] in_ax, in_ay, in_bx, in_by;
    logic [DIST_W-1:0]  in_dist;
    logic               out_valid;
    logic               out_ready;
    logic [COORD_W-1:0] out_x, out_y;
    logic [1:0]         out_idx;
    logic               out_last;
    logic               out_clip;
    logic               busy;

    int n_vec = 0;
    int n_err = 0;

    seg_buffer_stream #(.COORD_W(COORD_W), .DIST_W(DIST_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_ax(in_ax), .in_ay(in_ay), .in_bx(in_bx), .in_by(in_by), .in_dist(in_dist),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_x(out_x), .out_y(out_y), .out_idx(out_idx),
        .out_last(out_last), .out_clip(out_clip), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Present one segment for a single edge; returns at the falling edge of the CALC cycle.
    task automatic send_seg(input string name, input int ax, input int ay, input int bx,
                            input int by, input int d);
        in_ax    = COORD_W'(ax);
        in_ay    = COORD_W'(ay);
        in_bx    = COORD_W'(bx);
        in_by    = COORD_W'(by);
        in_dist  = DIST_W'(d);
        in_valid = 1'b1;
        chk({name, " in_ready_idle"}, 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk({name, " calc_vld"}, 32'(out_valid), 32'd0);
        chk({name, " calc_busy"}, 32'(busy), 32'd1);
    endtask

    // Consume n vertices with fixed latency; optionally stall at one index or poke in_valid.
    task automatic expect_rect(input string name, input int n, input int ex[4], input int ey[4],
                               input int exp_clip, input int stall_at, input int poke_at);
        @(negedge clk);
        chk({name, " first_vld"}, 32'(out_valid), 32'd1);
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s v%0d x", name, i), 32'(out_x), 32'(ex[i]));
            chk($sformatf("%s v%0d y", name, i), 32'(out_y), 32'(ey[i]));
            chk($sformatf("%s v%0d idx", name, i), 32'(out_idx), 32'(i));
            chk($sformatf("%s v%0d last", name, i), 32'(out_last), 32'(i == n - 1));
            chk($sformatf("%s v%0d clip", name, i), 32'(out_clip), 32'(exp_clip));
            chk($sformatf("%s v%0d in_ready", name, i), 32'(in_ready), 32'd0);
            if (i == poke_at) begin
                in_ax = 8'd200; in_ay = 8'd200; in_bx = 8'd201; in_by = 8'd201;
                in_dist = 4'd7; in_valid = 1'b1;
            end
            if (i == stall_at) begin
                out_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    @(negedge clk);
                    chk($sformatf("%s stall%0d vld", name, s), 32'(out_valid), 32'd1);
                    chk($sformatf("%s stall%0d x", name, s), 32'(out_x), 32'(ex[i]));
                    chk($sformatf("%s stall%0d y", name, s), 32'(out_y), 32'(ey[i]));
                    chk($sformatf("%s stall%0d idx", name, s), 32'(out_idx), 32'(i));
                end
                out_ready = 1'b1;
            end
            @(negedge clk);
            in_valid = 1'b0;
        end
        chk({name, " end_vld"}, 32'(out_valid), 32'd0);
        chk({name, " end_busy"}, 32'(busy), 32'd0);
        chk({name, " end_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    int c5_clip;
    int c5x[4];
    int c5y[4];

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_ax = '0; in_ay = '0; in_bx = '0; in_by = '0; in_dist = '0;
        repeat (3) @(negedge clk);
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst in_ready", 32'(in_ready), 32'd0);
        chk("rst out_x", 32'(out_x), 32'd0);
        chk("rst out_y", 32'(out_y), 32'd0);
        chk("rst out_idx", 32'(out_idx), 32'd0);
        chk("rst out_last", 32'(out_last), 32'd0);
        chk("rst out_clip", 32'(out_clip), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_rel in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);

        // 1: horizontal segment, dist 2
        send_seg("c1", 10, 20, 30, 20, 2);
        expect_rect("c1", 4, '{8, 32, 32, 8}, '{18, 18, 22, 22}, 0, -1, -1);

        // 2: swapped/diagonal endpoints, stray in_valid during EMIT
        send_seg("c2", 30, 22, 10, 18, 1);
        expect_rect("c2", 4, '{9, 31, 31, 9}, '{17, 17, 23, 23}, 0, -1, 1);

        // 3: case 1 with a 3-cycle stall at idx 1
        send_seg("c3", 10, 20, 30, 20, 2);
        expect_rect("c3", 4, '{8, 32, 32, 8}, '{18, 18, 22, 22}, 0, 1, -1);

        // 4: degenerate point
        send_seg("c4", 5, 5, 5, 5, 0);
        expect_rect("c4", 1, '{5, 0, 0, 0}, '{5, 0, 0, 0}, 0, -1, -1);

        // 5: underflowing corner
`ifdef SEG_BUFFER_SATURATE_EN
        c5x = '{0, 5, 5, 0};     c5y = '{0, 0, 5, 5};     c5_clip = 1;
`else
        c5x = '{255, 5, 5, 255}; c5y = '{255, 255, 5, 5}; c5_clip = 0;
`endif
        send_seg("c5", 1, 1, 3, 3, 2);
        expect_rect("c5", 4, c5x, c5y, c5_clip, -1, -1);

        // 6: reset in EMIT at idx 2
        send_seg("c6", 10, 20, 30, 20, 2);
        repeat (3) @(negedge clk);
        chk("c6 pre_rst idx", 32'(out_idx), 32'd2);
        rst_n = 1'b0;
        @(negedge clk);
        chk("c6 rst vld", 32'(out_valid), 32'd0);
        chk("c6 rst busy", 32'(busy), 32'd0);
        chk("c6 rst idx", 32'(out_idx), 32'd0);
        chk("c6 rst x", 32'(out_x), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("c6 rel in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        chk("c6 idle vld", 32'(out_valid), 32'd0);
        send_seg("c6b", 10, 20, 30, 20, 2);
        expect_rect("c6b", 4, '{8, 32, 32, 8}, '{18, 18, 22, 22}, 0, -1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/seg_buffer_stream.md
Name: seg_buffer_stream

Overview:
- Parametrised, sequential successor to the combinational point-offset buffer op in the tinyspu op set.
- Accepts one line segment (A, B) plus a runtime buffer distance over a valid/ready handshake.
- Computes the axis-aligned buffer rectangle of the segment: its bounding box grown by the distance on every side.
- Streams the rectangle's vertices out one per accepted beat, for the downstream polygon/op pipeline.

Parameters:
- COORD_W, 8, coordinate width in bits (unsigned).
- DIST_W, 4, buffer-distance width in bits (unsigned). Constraint: DIST_W <= COORD_W.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- in_valid  input  1  segment present on in_* this cycle.
- in_ready  output  1  block can accept a segment this cycle.
- in_ax, in_ay  input  COORD_W each  endpoint A.
- in_bx, in_by  input  COORD_W each  endpoint B.
- in_dist  input  DIST_W  buffer distance.
- out_valid  output  1  vertex present on out_*.
- out_ready  input  1  downstream accepts the vertex.
- out_x, out_y  output  COORD_W each  vertex coordinate.
- out_idx  output  2  vertex index, 0..3.
- out_last  output  1  final vertex of the current rectangle.
- out_clip  output  1  a coordinate of the current rectangle was clamped (see Optional Feature).
- busy  output  1  state != IDLE.

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE; out_valid=0, out_idx=0, out_last=0, out_clip=0, out_x=0, out_y=0; all captured registers cleared.
- Reset overrides any in-flight handshake. A segment or vertex pending at the reset edge is discarded; nothing partial is emitted afterwards.
- in_ready = (state==IDLE) & rst_n. It is combinational from registered state.
- FSM states: IDLE, CALC, EMIT.
  - IDLE: on in_valid & in_ready, register ax, ay, bx, by, dist and go to CALC. Inputs are ignored while not IDLE.
  - CALC (exactly 1 cycle):
    - xlo = min(ax,bx) - dist; xhi = max(ax,bx) + dist.
    - ylo = min(ay,by) - dist; yhi = max(ay,by) + dist.
    - Zero-extend dist to COORD_W. Compute at COORD_W+1 bits, then reduce to COORD_W (see Optional Feature).
    - Set degenerate = (xlo==xhi) & (ylo==yhi). Go to EMIT with idx=0.
  - EMIT:
    - out_valid=1. Vertex order: idx0 (xlo,ylo), idx1 (xhi,ylo), idx2 (xhi,yhi), idx3 (xlo,yhi).
    - out_last=1 on idx3, or on idx0 when degenerate.
    - A beat transfers on out_valid & out_ready. On transfer: if out_last, go to IDLE (out_valid=0 next cycle); otherwise idx+=1.
- Stability: while out_valid=1 and out_ready=0, out_x, out_y, out_idx, out_last and out_clip hold constant.
- Latency: segment accepted at edge k puts out_valid=1 in the cycle after edge k+1. Four-vertex rectangle with out_ready held at 1: last beat transfers at edge k+5. in_ready returns to 1 after edge k+5. Throughput is one segment per 6 cycles at best.
- Endpoint order is irrelevant: min/max normalise, so swapped A/B gives identical output.
- Degenerate case: a point with dist=0 emits exactly one vertex (idx0, out_last=1).
- in_dist=0 on a non-degenerate segment: emits 4 vertices. A horizontal or vertical segment gives a zero-height or zero-width rectangle.
- out_clip is valid with every vertex of the rectangle and is cleared on return to IDLE.

Optional Feature:
- Macro: SEG_BUFFER_SATURATE_EN.
- Defined: results below 0 clamp to 0; results above 2^COORD_W-1 clamp to 2^COORD_W-1. out_clip=1 for the whole rectangle if any of the four values was clamped.
- Undefined: results wrap modulo 2^COORD_W, and out_clip is tied to 0.
- Degenerate detection always uses the post-reduction values.

Test Plan:
1. COORD_W=8, DIST_W=4: A=(10,20), B=(30,20), dist=2, out_ready=1 -> vertices (8,18),(32,18),(32,22),(8,22); idx 0..3; out_last on 4th only; first out_valid in the cycle after edge k+1.
2. A=(30,22), B=(10,18), dist=1 -> (9,17),(31,17),(31,23),(9,23); in_ready=0 throughout; a second in_valid pulse during EMIT is ignored.
3. Backpressure: case 1 with out_ready=0 for 3 cycles while idx=1 -> out_x=32, out_y=18, out_idx=1 stable; sequence resumes unchanged.
4. A=B=(5,5), dist=0 -> single vertex (5,5), out_idx=0, out_last=1; back to IDLE next cycle.
5. A=(1,1), B=(3,3), dist=2:
   - Macro undefined -> (255,255),(5,255),(5,5),(255,5), out_clip=0.
   - SEG_BUFFER_SATURATE_EN defined -> (0,0),(5,0),(5,5),(0,5), out_clip=1.
6. rst_n=0 for one edge while EMIT at idx=2 -> next cycle out_valid=0, busy=0, in_ready=1 once rst_n=1; next segment (case 1) emits correctly from idx0.
